// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - shared prescaled 12-bit PWM counter with SLEEP/WAKE/RUN control (option: PWM_TIMEBASE_EXTCLK_EN)
module pwm_timebase #(
    parameter logic [7:0] PRESCALE_RESET = 8'd30,
    parameter logic [7:0] PRESCALE_MIN   = 8'd3,
    parameter int         WAKE_CYCLES    = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sleep_i,
    input  logic [7:0]  prescale_i,
    input  logic        prescale_we_i,
`ifdef PWM_TIMEBASE_EXTCLK_EN
    input  logic        extclk_i,
`endif
    output logic [11:0] counter_o,
    output logic        cycle_start_o,
    output logic        running_o,
    output logic [7:0]  prescale_o
);

    typedef enum logic [1:0] {
        ST_SLEEP = 2'd0,
        ST_WAKE  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam int             WCW       = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [WCW-1:0] WAKE_LAST = WCW'(WAKE_CYCLES - 1);

    state_e         state_q, state_d;
    logic [11:0]    counter_q, counter_d;
    logic [7:0]     div_q, div_d;
    logic [WCW-1:0] wake_cnt_q, wake_cnt_d;
    logic           cycle_start_q, cycle_start_d;
    logic           running_q, running_d;
    logic [7:0]     prescale_q, prescale_d;
    logic           tick;

    // Divider advance qualifier: every clock, or only on synchronised external pulses
`ifdef PWM_TIMEBASE_EXTCLK_EN
    always_comb tick = extclk_i;
`else
    always_comb tick = 1'b1;
`endif

    // Next-state logic: power state, wake delay, divider/counter and prescale register
    always_comb begin
        state_d       = state_q;
        counter_d     = counter_q;
        div_d         = div_q;
        wake_cnt_d    = wake_cnt_q;
        cycle_start_d = 1'b0;
        prescale_d    = prescale_q;

        // Prescale only changes while sleep is requested; a sleeping state machine
        // guarantees the divider is cleared before the new value is ever used.
        if (prescale_we_i && sleep_i) begin
            prescale_d = (prescale_i < PRESCALE_MIN) ? PRESCALE_MIN : prescale_i;
        end

        case (state_q)
            ST_SLEEP: begin
                counter_d  = 12'd0;
                div_d      = 8'd0;
                wake_cnt_d = '0;
                if (!sleep_i) begin
                    state_d = ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (sleep_i) begin
                    state_d = ST_SLEEP;
                end else if (wake_cnt_q == WAKE_LAST) begin
                    state_d       = ST_RUN;
                    counter_d     = 12'd0;
                    div_d         = 8'd0;
                    cycle_start_d = 1'b1;
                end else begin
                    wake_cnt_d = wake_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (sleep_i) begin
                    // No resume: the next wake always restarts the period from zero
                    state_d   = ST_SLEEP;
                    counter_d = 12'd0;
                    div_d     = 8'd0;
                end else if (tick) begin
                    if (div_q == prescale_q) begin
                        div_d         = 8'd0;
                        counter_d     = counter_q + 12'd1;
                        cycle_start_d = (counter_q == 12'hFFF);
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d   = ST_SLEEP;
                counter_d = 12'd0;
                div_d     = 8'd0;
            end
        endcase

        running_d = (state_d == ST_RUN);
    end

    // State and output registers with synchronous active-high reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_SLEEP;
            counter_q     <= 12'd0;
            div_q         <= 8'd0;
            wake_cnt_q    <= '0;
            cycle_start_q <= 1'b0;
            running_q     <= 1'b0;
            prescale_q    <= PRESCALE_RESET;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            div_q         <= div_d;
            wake_cnt_q    <= wake_cnt_d;
            cycle_start_q <= cycle_start_d;
            running_q     <= running_d;
            prescale_q    <= prescale_d;
        end
    end

    assign counter_o     = counter_q;
    assign cycle_start_o = cycle_start_q;
    assign running_o     = running_q;
    assign prescale_o    = prescale_q;

endmodule
